// File: rtl/picorv_prog_loader.sv
// Program loader for the PicoRV32 wrapper: streams an image into instruction
// memory while the core is held in reset, releases the core after a short
// settle window, and watches trap to mark completion.
module picorv_prog_loader #(
  parameter int unsigned ADDR_WIDTH     = 13,
  parameter int unsigned MEM_WORDS      = 8192,
  parameter int unsigned RELEASE_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  load_start,
  input  logic                  abort,
  input  logic                  s_valid,
  input  logic [31:0]           s_data,
  input  logic                  s_last,
  output logic                  s_ready,
  output logic                  inst_mem_en,
  output logic [3:0]            inst_mem_wen,
  output logic [ADDR_WIDTH-1:0] inst_mem_addr,
  output logic [31:0]           inst_mem_data,
  output logic                  core_resetn,
  output logic                  core_clk_en,
  input  logic                  trap,
  output logic                  busy,
  output logic                  running,
  output logic                  done,
  output logic                  overflow,
  output logic [ADDR_WIDTH:0]   words_loaded
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_DRAIN,
    S_RELEASE,
    S_RUN,
    S_DONE
  } state_e;

  localparam logic [ADDR_WIDTH:0] LAST_PTR = (ADDR_WIDTH+1)'(MEM_WORDS - 1);
  localparam logic [ADDR_WIDTH:0] PTR_INC  = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [7:0]          CNT_INIT = 8'(RELEASE_CYCLES - 1);

  state_e                state_q, state_d;
  // Write pointer doubles as the words_loaded count: both advance on every
  // stored word and both restart on load_start.
  logic [ADDR_WIDTH:0]   ptr_q, ptr_d;
  logic [7:0]            cnt_q, cnt_d;
  logic                  done_q, done_d;
  logic                  ovf_q, ovf_d;
  logic                  wr_d;
  logic                  s_ready_q;
  logic                  en_q;
  logic [3:0]            wen_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [31:0]           data_q;
  logic                  core_resetn_q;
  logic                  core_clk_en_q;
  logic                  busy_q;
  logic                  running_q;
  logic                  accept;

  assign accept = s_valid & s_ready_q;

  // Next-state, pointer, release counter and sticky flag computation.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    done_d  = done_q;
    ovf_d   = ovf_q;
    wr_d    = 1'b0;
    if (abort) begin
      state_d = S_IDLE;
      done_d  = 1'b0;
      ovf_d   = 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (load_start) begin
            state_d = S_LOAD;
            ptr_d   = '0;
            done_d  = 1'b0;
            ovf_d   = 1'b0;
          end
        end
        S_LOAD: begin
          if (accept) begin
            wr_d  = 1'b1;
            ptr_d = ptr_q + PTR_INC;
            if (s_last) begin
              state_d = S_RELEASE;
              cnt_d   = CNT_INIT;
            end else if (ptr_q == LAST_PTR) begin
              state_d = S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          // Every word accepted here is discarded, so the closing s_last
          // always sees overflow set and abandons the image.
          if (accept) begin
            ovf_d = 1'b1;
            if (s_last) state_d = S_IDLE;
          end
        end
        S_RELEASE: begin
          if (cnt_q == 8'd0) state_d = S_RUN;
          else               cnt_d   = cnt_q - 8'd1;
        end
        S_RUN: begin
          if (trap) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // State register with all outputs registered from the next state.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q       <= S_IDLE;
      ptr_q         <= '0;
      cnt_q         <= '0;
      done_q        <= 1'b0;
      ovf_q         <= 1'b0;
      s_ready_q     <= 1'b0;
      en_q          <= 1'b0;
      wen_q         <= '0;
      addr_q        <= '0;
      data_q        <= '0;
      core_resetn_q <= 1'b0;
      core_clk_en_q <= 1'b0;
      busy_q        <= 1'b0;
      running_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      cnt_q         <= cnt_d;
      done_q        <= done_d;
      ovf_q         <= ovf_d;
      s_ready_q     <= (state_d == S_LOAD) || (state_d == S_DRAIN);
      en_q          <= wr_d;
      wen_q         <= wr_d ? 4'hF : 4'h0;
      if (wr_d) begin
        addr_q <= ptr_q[ADDR_WIDTH-1:0];
        data_q <= s_data;
      end
      core_resetn_q <= (state_d == S_RUN) || (state_d == S_DONE);
      core_clk_en_q <= (state_d == S_RELEASE) || (state_d == S_RUN);
      busy_q        <= (state_d == S_LOAD) || (state_d == S_DRAIN) ||
                       (state_d == S_RELEASE);
      running_q     <= (state_d == S_RUN);
    end
  end

  assign s_ready       = s_ready_q;
  assign inst_mem_en   = en_q;
  assign inst_mem_wen  = wen_q;
  assign inst_mem_addr = addr_q;
  assign inst_mem_data = data_q;
  assign core_resetn   = core_resetn_q;
  assign core_clk_en   = core_clk_en_q;
  assign busy          = busy_q;
  assign running       = running_q;
  assign done          = done_q;
  assign overflow      = ovf_q;
  assign words_loaded  = ptr_q;

endmodule

// File: tb/tb_picorv_prog_loader.sv
// Self-checking bench for picorv_prog_loader (8-word memory, 4 release cycles).
module tb_picorv_prog_loader;

  logic        clk;
  logic        resetn;
  logic        load_start;
  logic        abort;
  logic        s_valid;
  logic [31:0] s_data;
  logic        s_last;
  logic        s_ready;
  logic        inst_mem_en;
  logic [3:0]  inst_mem_wen;
  logic [3:0]  inst_mem_addr;
  logic [31:0] inst_mem_data;
  logic        core_resetn;
  logic        core_clk_en;
  logic        trap;
  logic        busy;
  logic        running;
  logic        done;
  logic        overflow;
  logic [4:0]  words_loaded;

  int n_checks = 0;
  int n_fail   = 0;

  picorv_prog_loader #(
    .ADDR_WIDTH    (4),
    .MEM_WORDS     (8),
    .RELEASE_CYCLES(4)
  ) dut (
    .clk          (clk),
    .resetn       (resetn),
    .load_start   (load_start),
    .abort        (abort),
    .s_valid      (s_valid),
    .s_data       (s_data),
    .s_last       (s_last),
    .s_ready      (s_ready),
    .inst_mem_en  (inst_mem_en),
    .inst_mem_wen (inst_mem_wen),
    .inst_mem_addr(inst_mem_addr),
    .inst_mem_data(inst_mem_data),
    .core_resetn  (core_resetn),
    .core_clk_en  (core_clk_en),
    .trap         (trap),
    .busy         (busy),
    .running      (running),
    .done         (done),
    .overflow     (overflow),
    .words_loaded (words_loaded)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        ls, ab, v, l, tr;
    logic [31:0] d;
    logic        rdy, en;
    logic [3:0]  a;
    logic [31:0] dat;
    logic        rstn, cke, bsy, run, dn, ov;
    logic [4:0]  wl;
  } vec_t;

  vec_t tbl[$];

  // in = {load_start, abort, s_valid, s_last, trap}
  // re = {s_ready, inst_mem_en}
  // fl = {core_resetn, core_clk_en, busy, running, done, overflow}
  function automatic vec_t mk(input logic [4:0] in, input logic [31:0] d,
                              input logic [1:0] re, input logic [3:0] a,
                              input logic [31:0] dat, input logic [5:0] fl,
                              input logic [4:0] wl);
    vec_t r;
    {r.ls, r.ab, r.v, r.l, r.tr} = in;
    r.d = d;
    {r.rdy, r.en} = re;
    r.a = a;
    r.dat = dat;
    {r.rstn, r.cke, r.bsy, r.run, r.dn, r.ov} = fl;
    r.wl = wl;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic chk_vec(input string nm, input vec_t e);
    chk({nm, ".s_ready"},      s_ready,      e.rdy);
    chk({nm, ".en"},           inst_mem_en,  e.en);
    chk({nm, ".wen"},          inst_mem_wen, e.en ? 4'hF : 4'h0);
    if (e.en) begin
      chk({nm, ".addr"}, inst_mem_addr, e.a);
      chk({nm, ".data"}, inst_mem_data, e.dat);
    end
    chk({nm, ".core_resetn"},  core_resetn,  e.rstn);
    chk({nm, ".core_clk_en"},  core_clk_en,  e.cke);
    chk({nm, ".busy"},         busy,         e.bsy);
    chk({nm, ".running"},      running,      e.run);
    chk({nm, ".done"},         done,         e.dn);
    chk({nm, ".overflow"},     overflow,     e.ov);
    chk({nm, ".words_loaded"}, words_loaded, e.wl);
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, ".s_ready"},      s_ready,       0);
    chk({nm, ".en"},           inst_mem_en,   0);
    chk({nm, ".wen"},          inst_mem_wen,  0);
    chk({nm, ".addr"},         inst_mem_addr, 0);
    chk({nm, ".data"},         inst_mem_data, 0);
    chk({nm, ".core_resetn"},  core_resetn,   0);
    chk({nm, ".core_clk_en"},  core_clk_en,   0);
    chk({nm, ".busy"},         busy,          0);
    chk({nm, ".running"},      running,       0);
    chk({nm, ".done"},         done,          0);
    chk({nm, ".overflow"},     overflow,      0);
    chk({nm, ".words_loaded"}, words_loaded,  0);
  endtask

  task automatic idle_inputs();
    load_start = 1'b0;
    abort      = 1'b0;
    s_valid    = 1'b0;
    s_data     = '0;
    s_last     = 1'b0;
    trap       = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int k;
    int nw;
    logic acc;

    resetn = 1'b0;
    idle_inputs();
    step();
    step();
    chk_all_zero("reset");
    resetn = 1'b1;

    // T2/T5/T6: 5-word load, release timing, trap, ignored load_start, abort cases
    tbl.push_back(mk(5'b10000, 32'h00,       2'b10, 4'd0, 32'h00,       6'b001000, 5'd0));
    tbl.push_back(mk(5'b00100, 32'h00000013, 2'b11, 4'd0, 32'h00000013, 6'b001000, 5'd1));
    tbl.push_back(mk(5'b00100, 32'h00000014, 2'b11, 4'd1, 32'h00000014, 6'b001000, 5'd2));
    tbl.push_back(mk(5'b10000, 32'hFF,       2'b10, 4'd0, 32'h00,       6'b001000, 5'd2));
    tbl.push_back(mk(5'b00100, 32'h00000015, 2'b11, 4'd2, 32'h00000015, 6'b001000, 5'd3));
    tbl.push_back(mk(5'b00100, 32'h00000016, 2'b11, 4'd3, 32'h00000016, 6'b001000, 5'd4));
    tbl.push_back(mk(5'b00110, 32'h00000017, 2'b01, 4'd4, 32'h00000017, 6'b011000, 5'd5));
    tbl.push_back(mk(5'b00100, 32'h99,       2'b00, 4'd0, 32'h00,       6'b011000, 5'd5));
    tbl.push_back(mk(5'b00001, 32'h00,       2'b00, 4'd0, 32'h00,       6'b011000, 5'd5));
    tbl.push_back(mk(5'b00000, 32'h00,       2'b00, 4'd0, 32'h00,       6'b011000, 5'd5));
    tbl.push_back(mk(5'b00000, 32'h00,       2'b00, 4'd0, 32'h00,       6'b110100, 5'd5));
    tbl.push_back(mk(5'b10000, 32'h00,       2'b00, 4'd0, 32'h00,       6'b110100, 5'd5));
    tbl.push_back(mk(5'b00001, 32'h00,       2'b00, 4'd0, 32'h00,       6'b100010, 5'd5));
    tbl.push_back(mk(5'b00000, 32'h00,       2'b00, 4'd0, 32'h00,       6'b100010, 5'd5));
    tbl.push_back(mk(5'b11000, 32'h00,       2'b00, 4'd0, 32'h00,       6'b000000, 5'd5));
    tbl.push_back(mk(5'b10000, 32'h00,       2'b10, 4'd0, 32'h00,       6'b001000, 5'd0));
    tbl.push_back(mk(5'b00110, 32'hAA,       2'b01, 4'd0, 32'hAA,       6'b011000, 5'd1));
    tbl.push_back(mk(5'b01000, 32'h00,       2'b00, 4'd0, 32'h00,       6'b000000, 5'd1));
    tbl.push_back(mk(5'b00000, 32'h00,       2'b00, 4'd0, 32'h00,       6'b000000, 5'd1));
    tbl.push_back(mk(5'b10000, 32'h00,       2'b10, 4'd0, 32'h00,       6'b001000, 5'd0));
    tbl.push_back(mk(5'b00110, 32'h55,       2'b01, 4'd0, 32'h55,       6'b011000, 5'd1));
    tbl.push_back(mk(5'b00000, 32'h00,       2'b00, 4'd0, 32'h00,       6'b011000, 5'd1));
    tbl.push_back(mk(5'b00000, 32'h00,       2'b00, 4'd0, 32'h00,       6'b011000, 5'd1));
    tbl.push_back(mk(5'b00000, 32'h00,       2'b00, 4'd0, 32'h00,       6'b011000, 5'd1));
    tbl.push_back(mk(5'b00000, 32'h00,       2'b00, 4'd0, 32'h00,       6'b110100, 5'd1));
    tbl.push_back(mk(5'b00001, 32'h00,       2'b00, 4'd0, 32'h00,       6'b100010, 5'd1));
    tbl.push_back(mk(5'b10000, 32'h00,       2'b10, 4'd0, 32'h00,       6'b001000, 5'd0));
    tbl.push_back(mk(5'b01000, 32'h00,       2'b00, 4'd0, 32'h00,       6'b000000, 5'd0));

    for (int i = 0; i < tbl.size(); i++) begin
      load_start = tbl[i].ls;
      abort      = tbl[i].ab;
      s_valid    = tbl[i].v;
      s_last     = tbl[i].l;
      trap       = tbl[i].tr;
      s_data     = tbl[i].d;
      step();
      chk_vec($sformatf("vec%0d", i), tbl[i]);
    end
    idle_inputs();

    // T3: 10-word image into 8-word memory
    load_start = 1'b1;
    step();
    load_start = 1'b0;
    chk("t3_start.s_ready", s_ready, 1);
    for (int i = 0; i < 10; i++) begin
      s_valid = 1'b1;
      s_data  = 32'h100 + i;
      s_last  = (i == 9);
      step();
      chk($sformatf("t3_w%0d.en", i), inst_mem_en, (i < 8) ? 1 : 0);
      if (i < 8) begin
        chk($sformatf("t3_w%0d.addr", i), inst_mem_addr, i);
        chk($sformatf("t3_w%0d.data", i), inst_mem_data, 32'h100 + i);
      end
      chk($sformatf("t3_w%0d.overflow", i), overflow, (i >= 8) ? 1 : 0);
      chk($sformatf("t3_w%0d.s_ready", i), s_ready, (i < 9) ? 1 : 0);
      chk($sformatf("t3_w%0d.busy", i), busy, (i < 9) ? 1 : 0);
      chk($sformatf("t3_w%0d.words_loaded", i), words_loaded, (i < 8) ? i + 1 : 8);
      chk($sformatf("t3_w%0d.core_resetn", i), core_resetn, 0);
    end
    idle_inputs();
    for (int i = 0; i < 5; i++) begin
      step();
      chk($sformatf("t3_idle%0d.core_resetn", i), core_resetn, 0);
      chk($sformatf("t3_idle%0d.core_clk_en", i), core_clk_en, 0);
      chk($sformatf("t3_idle%0d.en", i), inst_mem_en, 0);
      chk($sformatf("t3_idle%0d.overflow", i), overflow, 1);
    end

    // T4: exact-fit 8-word image with random s_valid gaps
    load_start = 1'b1;
    step();
    load_start = 1'b0;
    chk("t4_start.overflow", overflow, 0);
    chk("t4_start.words_loaded", words_loaded, 0);
    k  = 0;
    nw = 0;
    for (int cyc = 0; cyc < 300 && nw < 8; cyc++) begin
      if (k < 8) begin
        s_valid = 1'($urandom_range(0, 1));
        s_data  = 32'hC000_0000 + k;
        s_last  = (k == 7);
      end else begin
        s_valid = 1'b0;
        s_last  = 1'b0;
      end
      acc = s_valid & s_ready;
      step();
      if (acc) k++;
      if (inst_mem_en) begin
        chk($sformatf("t4_w%0d.addr", nw), inst_mem_addr, nw);
        chk($sformatf("t4_w%0d.data", nw), inst_mem_data, 32'hC000_0000 + nw);
        chk($sformatf("t4_w%0d.wen", nw), inst_mem_wen, 4'hF);
        chk($sformatf("t4_w%0d.accepted", nw), k, nw + 1);
        nw++;
      end
    end
    idle_inputs();
    chk("t4_writes", nw, 8);
    chk("t4.words_loaded", words_loaded, 8);
    chk("t4.overflow", overflow, 0);
    chk("t4.s_ready", s_ready, 0);
    chk("t4_rel0.core_resetn", core_resetn, 0);
    for (int i = 1; i < 4; i++) begin
      step();
      chk($sformatf("t4_rel%0d.core_resetn", i), core_resetn, 0);
      chk($sformatf("t4_rel%0d.en", i), inst_mem_en, 0);
    end
    step();
    chk("t4_run.core_resetn", core_resetn, 1);
    chk("t4_run.running", running, 1);

    // T1: asynchronous reset in the middle of a load
    abort = 1'b1;
    step();
    abort = 1'b0;
    load_start = 1'b1;
    step();
    load_start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      s_valid = 1'b1;
      s_data  = 32'hD00 + i;
      s_last  = 1'b0;
      step();
      chk($sformatf("t1_w%0d.addr", i), inst_mem_addr, i);
    end
    #2;
    resetn = 1'b0;
    #1;
    chk_all_zero("t1_async");
    step();
    step();
    chk_all_zero("t1_held");
    resetn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("t1_after%0d.en", i), inst_mem_en, 0);
      chk($sformatf("t1_after%0d.s_ready", i), s_ready, 0);
      chk($sformatf("t1_after%0d.busy", i), busy, 0);
      chk($sformatf("t1_after%0d.words_loaded", i), words_loaded, 0);
    end
    idle_inputs();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
